// File: rtl/preset_load_ctrl.sv
// Button front end for the loadable down-counter: synchronises and debounces
// up/down/go, steps a 3-bit preset and issues rate-limited single-cycle loads.
module preset_load_ctrl #(
   parameter int DB_CYCLES = 4,
   parameter int HOLDOFF   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_go,
   output logic [2:0] preset,
   output logic       load,
   output logic [2:0] din,
   output logic       busy
);

   localparam logic [7:0] DC_LAST   = 8'(DB_CYCLES - 1);
   localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

   // Bit 0 = up, bit 1 = down, bit 2 = go.
   logic [2:0] raw;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] db;
   logic [2:0] db_q;
   logic [2:0] press;
   logic [7:0] dc [3];
   logic [7:0] hold_cnt;
   logic       up_p;
   logic       down_p;
   logic       go_p;

   assign raw    = {btn_go, btn_down, btn_up};
   assign press  = db & ~db_q;
   assign up_p   = press[0];
   assign down_p = press[1];
   assign go_p   = press[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         db   <= '0;
         db_q <= '0;
         for (int i = 0; i < 3; i++) dc[i] <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         db_q <= db;
         // The debounced level only follows s2 after DB_CYCLES consecutive disagreements.
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == db[i]) begin
               dc[i] <= '0;
            end else if (dc[i] == DC_LAST) begin
               db[i] <= s2[i];
               dc[i] <= '0;
            end else begin
               dc[i] <= dc[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         preset   <= '0;
         load     <= 1'b0;
         din      <= '0;
         hold_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         load <= 1'b0;
         // din captures the preset before any same-cycle up/down step lands.
         if (go_p && hold_cnt == 8'd0) begin
            load     <= 1'b1;
            din      <= preset;
            hold_cnt <= HOLD_INIT;
            busy     <= 1'b1;
         end else if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
            busy     <= (hold_cnt != 8'd1);
         end

         if (up_p && !down_p) begin
            preset <= preset + 3'd1;
         end else if (down_p && !up_p) begin
            preset <= preset - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_preset_load_ctrl.sv
// Bench for preset_load_ctrl: directed timing scenarios plus randomized button
// sequences checked against an event-level model of presses, preset and loads.
module tb_preset_load_ctrl;

   localparam int DB = 4;
   localparam int HO = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up;
   logic       btn_down;
   logic       btn_go;
   logic [2:0] preset;
   logic       load;
   logic [2:0] din;
   logic       busy;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   logic [2:0] exp_q[$];
   bit         sb_on     = 1'b0;
   logic       load_prev = 1'b0;

   preset_load_ctrl #(.DB_CYCLES(DB), .HOLDOFF(HO)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_go   (btn_go),
      .preset   (preset),
      .load     (load),
      .din      (din),
      .busy     (busy)
   );

   // Clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every load pulse is checked on the falling edge.
   always @(negedge clk) begin
      logic [2:0] e;
      if (load === 1'b1) begin
         checks++;
         if (load_prev === 1'b1) $display("FAIL load_repeat load high two cycles in a row at cycle %0d", cyc);
         else passed++;
         if (sb_on) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected_load din=%0d with no load expected at cycle %0d", din, cyc);
            end else begin
               e = exp_q.pop_front();
               if (din !== e) $display("FAIL sb_din din=%0d expected=%0d at cycle %0d", din, e, cyc);
               else passed++;
            end
         end
      end
      load_prev = load;
   end

   // Drivers
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_go   = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic press(input logic [2:0] mask, input int hold, input int gap);
      {btn_go, btn_down, btn_up} = mask;
      tick(hold);
      {btn_go, btn_down, btn_up} = 3'b000;
      tick(gap);
   endtask

   // Tests
   task automatic test_reset();
      reset    = 1'b1;
      btn_up   = 1'b1;
      btn_down = 1'b0;
      btn_go   = 1'b1;
      tick(2);
      checks++; if (preset !== 3'd0) $display("FAIL reset_preset got=%0d exp=0", preset); else passed++;
      checks++; if (load !== 1'b0)   $display("FAIL reset_load got=%0b exp=0", load); else passed++;
      checks++; if (din !== 3'd0)    $display("FAIL reset_din got=%0d exp=0", din); else passed++;
      checks++; if (busy !== 1'b0)   $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
      btn_up = 1'b0;
      btn_go = 1'b0;
      reset  = 1'b0;
      tick(10);
   endtask

   task automatic test_hold_up();
      do_reset();
      btn_up = 1'b1;
      tick(DB + 2);
      checks++; if (preset !== 3'd0) $display("FAIL up_before_edge got=%0d exp=0", preset); else passed++;
      tick(1);
      checks++; if (preset !== 3'd1) $display("FAIL up_latency got=%0d exp=1", preset); else passed++;
      tick(20);
      checks++; if (preset !== 3'd1) $display("FAIL up_held_once got=%0d exp=1", preset); else passed++;
      btn_up = 1'b0;
      tick(6);
      press(3'b001, 5, 5);
      press(3'b001, 5, 5);
      checks++; if (preset !== 3'd3) $display("FAIL up_two_more got=%0d exp=3", preset); else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      press(3'b010, 5, 5);
      checks++; if (preset !== 3'd7) $display("FAIL down_wrap got=%0d exp=7", preset); else passed++;
      for (int i = 0; i < 8; i++) begin
         press(3'b001, 5, 5);
         if (i == 0) begin
            checks++; if (preset !== 3'd0) $display("FAIL up_wrap got=%0d exp=0", preset); else passed++;
         end
      end
      checks++; if (preset !== 3'd7) $display("FAIL up_full_circle got=%0d exp=7", preset); else passed++;
   endtask

   task automatic test_go_holdoff();
      logic exp_load;
      logic exp_busy;
      do_reset();
      for (int i = 0; i < 5; i++) press(3'b001, 5, 5);
      checks++; if (preset !== 3'd5) $display("FAIL go_setup_preset got=%0d exp=5", preset); else passed++;
      // First go held 4 cycles; second go starts 8 cycles later and lands while busy.
      btn_go = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         tick(1);
         exp_load = (t == 7);
         exp_busy = (t >= 7 && t <= 14);
         checks++; if (load !== exp_load) $display("FAIL go_load t=%0d got=%0b exp=%0b", t, load, exp_load); else passed++;
         checks++; if (busy !== exp_busy) $display("FAIL go_busy t=%0d got=%0b exp=%0b", t, busy, exp_busy); else passed++;
         if (t == 7) begin
            checks++; if (din !== 3'd5) $display("FAIL go_din got=%0d exp=5", din); else passed++;
         end
         if (t == 4)  btn_go = 1'b0;
         if (t == 8)  btn_go = 1'b1;
         if (t == 12) btn_go = 1'b0;
      end
      tick(10);
   endtask

   task automatic test_same_cycle();
      do_reset();
      press(3'b001, 5, 5);
      press(3'b001, 5, 5);
      {btn_go, btn_down, btn_up} = 3'b101;
      for (int t = 1; t <= 8; t++) begin
         tick(1);
         if (t == 5) {btn_go, btn_down, btn_up} = 3'b000;
         if (t == 6) begin
            checks++; if (preset !== 3'd2) $display("FAIL sc_preset_before got=%0d exp=2", preset); else passed++;
         end
         if (t == 7) begin
            checks++; if (load !== 1'b1)   $display("FAIL sc_load got=%0b exp=1", load); else passed++;
            checks++; if (din !== 3'd2)    $display("FAIL sc_din got=%0d exp=2", din); else passed++;
            checks++; if (preset !== 3'd3) $display("FAIL sc_preset_after got=%0d exp=3", preset); else passed++;
         end
      end
      tick(12);
      press(3'b011, 5, 5);
      checks++; if (preset !== 3'd3) $display("FAIL up_down_cancel got=%0d exp=3", preset); else passed++;
   endtask

   task automatic test_glitch_and_reset();
      int bad_load;
      int bad_busy;
      do_reset();
      btn_go = 1'b1;
      tick(DB - 1);
      btn_go = 1'b0;
      bad_load = 0;
      bad_busy = 0;
      for (int t = 0; t < 15; t++) begin
         tick(1);
         if (load !== 1'b0) bad_load++;
         if (busy !== 1'b0) bad_busy++;
      end
      checks++; if (bad_load != 0) $display("FAIL glitch_load cycles_high=%0d exp=0", bad_load); else passed++;
      checks++; if (bad_busy != 0) $display("FAIL glitch_busy cycles_high=%0d exp=0", bad_busy); else passed++;

      btn_go = 1'b1;
      tick(5);
      btn_go = 1'b0;
      tick(2);
      checks++; if (load !== 1'b1) $display("FAIL rst_setup_load got=%0b exp=1", load); else passed++;
      tick(2);
      checks++; if (busy !== 1'b1) $display("FAIL rst_setup_busy got=%0b exp=1", busy); else passed++;
      reset = 1'b1;
      tick(1);
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else passed++;
      checks++; if (load !== 1'b0) $display("FAIL rst_load got=%0b exp=0", load); else passed++;
      reset = 1'b0;
      tick(1);
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy_after got=%0b exp=0", busy); else passed++;
   endtask

   // Random clean presses against an event-level model: each press takes
   // effect DB+2 edges after it is first sampled; a go is accepted only if
   // more than HO edges have passed since the last accepted load.
   task automatic test_random();
      logic [2:0] mask;
      logic [2:0] preset_m;
      int         hold;
      int         gap;
      int         c;
      int         pe;
      int         last_load;
      do_reset();
      exp_q.delete();
      sb_on     = 1'b1;
      preset_m  = 3'd0;
      last_load = -1000;
      for (int i = 0; i < 40; i++) begin
         mask = 3'($urandom_range(1, 7));
         hold = $urandom_range(DB, DB + 3);
         gap  = $urandom_range(DB, DB + 5);
         c    = cyc;
         pe   = c + 1 + DB + 2;
         if (mask[2] && (pe - last_load) > HO) begin
            exp_q.push_back(preset_m);
            last_load = pe;
         end
         if (mask[0] && !mask[1]) preset_m = preset_m + 3'd1;
         if (mask[1] && !mask[0]) preset_m = preset_m - 3'd1;
         press(mask, hold, gap);
         checks++; if (preset !== preset_m) $display("FAIL rand_preset iter=%0d got=%0d exp=%0d", i, preset, preset_m); else passed++;
      end
      tick(20);
      checks++; if (exp_q.size() != 0) $display("FAIL rand_missing_loads left=%0d exp=0", exp_q.size()); else passed++;
      sb_on = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_go   = 1'b0;
      test_reset();
      test_hold_up();
      test_wrap();
      test_go_holdoff();
      test_same_cycle();
      test_glitch_and_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
